image_stream_ctrl: RTL and testbench

IMAGE_STREAM_CTRL -- requirements
Module: image_stream_ctrl

---
 rtl/image_stream_ctrl.sv | 155 +++++++++++++++
 tb/tb_image_stream_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_ctrl.sv
// Frame-buffer streaming controller: generates vsync/hsync timing, reads pixel pairs in raster
// order, and applies one of four per-pixel operations through a two-stage pipeline.
module image_stream_ctrl #(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int VSYNC_DELAY = 100,
  parameter int HSYNC_DELAY = 160,
  parameter int BRIGHT_VAL  = 100,
  parameter int THRESH      = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op_sel,
  output logic        rd_en,
  output logic [17:0] rd_addr,
  input  logic [47:0] rd_data,
  output logic        vsync,
  output logic        hsync,
  output logic [7:0]  DATA_R0,
  output logic [7:0]  DATA_G0,
  output logic [7:0]  DATA_B0,
  output logic [7:0]  DATA_R1,
  output logic [7:0]  DATA_G1,
  output logic [7:0]  DATA_B1,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [17:0] LastCol   = 18'(WIDTH / 2 - 1);
  localparam logic [17:0] LastRow   = 18'(HEIGHT - 1);
  localparam logic [15:0] VLast     = 16'(VSYNC_DELAY - 1);
  localparam logic [15:0] HLast     = 16'(HSYNC_DELAY - 1);
  localparam logic [8:0]  Bright    = 9'(BRIGHT_VAL);
  localparam logic [9:0]  ThreshSum = 10'(3 * THRESH);

  typedef enum logic [2:0] {StIdle, StVsync, StHsync, StData, StDone} state_e;

  state_e      r_state;
  logic [1:0]  r_op;
  logic [15:0] r_cnt;
  logic [17:0] r_col;
  logic [17:0] r_row;
  logic        r_v1;
  logic [47:0] r_px;
  logic [47:0] w_px;

  function automatic logic [7:0] f_chan(input logic [1:0] op, input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, v} + Bright;
    case (op)
      2'b01:   return ~v;
      2'b10:   return sum[8] ? 8'hFF : sum[7:0];
      default: return v;
    endcase
  endfunction

  function automatic logic [23:0] f_pixel(input logic [1:0] op, input logic [23:0] p);
    logic [9:0] sum;
    sum = 10'(p[23:16]) + 10'(p[15:8]) + 10'(p[7:0]);
    if (op == 2'b11) return (sum >= ThreshSum) ? 24'hFFFFFF : 24'h000000;
    return {f_chan(op, p[23:16]), f_chan(op, p[15:8]), f_chan(op, p[7:0])};
  endfunction

  assign w_px = {f_pixel(r_op, rd_data[47:24]), f_pixel(r_op, rd_data[23:0])};
  assign {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = r_px;

  // Stage 1 tracks the memory read latency, stage 2 registers the processed pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      hsync <= 1'b0;
      r_px  <= '0;
    end else begin
      r_v1  <= rd_en;
      hsync <= r_v1;
      r_px  <= r_v1 ? w_px : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_op       <= 2'b00;
      r_cnt      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      vsync      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            r_op    <= op_sel;
            vsync   <= 1'b1;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= StVsync;
          end
        end
        StVsync: begin
          if (r_cnt == VLast) begin
            vsync   <= 1'b0;
            r_cnt   <= '0;
            r_state <= StHsync;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StHsync: begin
          if (r_cnt == HLast) begin
            rd_en   <= 1'b1;
            // Rows are contiguous, so each new row continues from the previous last address.
            rd_addr <= (r_row == '0) ? '0 : rd_addr + 18'd1;
            r_col   <= '0;
            r_cnt   <= '0;
            r_state <= StData;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StData: begin
          if (r_col == LastCol) begin
            rd_en <= 1'b0;
            if (r_row == LastRow) begin
              r_state <= StDone;
            end else begin
              r_row   <= r_row + 18'd1;
              r_state <= StHsync;
            end
          end else begin
            r_col   <= r_col + 18'd1;
            rd_addr <= rd_addr + 18'd1;
          end
        end
        StDone: begin
          // Final pair is in the output register once stage 1 drains.
          if (!r_v1) begin
            frame_done <= 1'b1;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Self-checking bench for image_stream_ctrl on a 4x2 frame with randomized pixel data.
module tb_image_stream_ctrl;
  localparam int W = 4;
  localparam int H = 2;
  localparam int V = 3;
  localparam int HD = 2;
  localparam int BRIGHT = 100;
  localparam int TH = 90;
  localparam int NPAIR = W * H / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op_sel;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [47:0] rd_data = '0;
  logic        vsync, hsync, busy, frame_done;
  logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic [47:0] w_dout;

  logic [47:0] mem [NPAIR];

  int n_tests = 0;
  int n_fail  = 0;

  int          vs_cnt, vs_first, zero_viol, hold_viol;
  int          rd_cyc[$];
  logic [17:0] rd_adr[$];
  int          hs_cyc[$];
  logic [47:0] hs_dat[$];
  int          fd_cyc[$];
  logic [63:0] busy_log;

  image_stream_ctrl #(
    .WIDTH(W), .HEIGHT(H), .VSYNC_DELAY(V), .HSYNC_DELAY(HD), .BRIGHT_VAL(BRIGHT), .THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .vsync(vsync), .hsync(hsync), .DATA_R0(DATA_R0), .DATA_G0(DATA_G0),
    .DATA_B0(DATA_B0), .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1), .busy(busy),
    .frame_done(frame_done)
  );

  assign w_dout = {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[1:0]];

  function automatic logic [23:0] model_px(input logic [1:0] op, input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (op)
      2'd1: begin r = 255 - r; g = 255 - g; b = 255 - b; end
      2'd2: begin
        r = (r + BRIGHT > 255) ? 255 : r + BRIGHT;
        g = (g + BRIGHT > 255) ? 255 : g + BRIGHT;
        b = (b + BRIGHT > 255) ? 255 : b + BRIGHT;
      end
      2'd3: begin
        if (r + g + b >= 3 * TH) begin r = 255; g = 255; b = 255; end
        else begin r = 0; g = 0; b = 0; end
      end
      default: ;
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [47:0] model_pair(input logic [1:0] op, input logic [47:0] p);
    return {model_px(op, p[47:24]), model_px(op, p[23:0])};
  endfunction

  // Expected cycle (counted from the start-accepting edge) at which pair i is read.
  function automatic int exp_rd_cyc(input int i);
    return V + HD + 1 + (i / (W / 2)) * (W / 2 + HD) + (i % (W / 2));
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < NPAIR; i++) mem[i] = {$urandom, $urandom};
  endfunction

  // Launches a frame with op and records every output for ncyc cycles.
  task automatic capture(input logic [1:0] op, input int ncyc, input int inj_cyc,
                         input logic [1:0] inj_op);
    logic [17:0] prev_addr;
    @(negedge clk);
    vs_cnt = 0; vs_first = -1; zero_viol = 0; hold_viol = 0; busy_log = '0;
    rd_cyc.delete(); rd_adr.delete(); hs_cyc.delete(); hs_dat.delete(); fd_cyc.delete();
    prev_addr = rd_addr;
    start = 1'b1;
    op_sel = op;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (k == 1) op_sel = 2'($urandom);
      if (vsync) begin vs_cnt++; if (vs_first < 0) vs_first = k; end
      if (rd_en) begin rd_cyc.push_back(k); rd_adr.push_back(rd_addr); end
      else if (rd_addr !== prev_addr) hold_viol++;
      prev_addr = rd_addr;
      if (hsync) begin hs_cyc.push_back(k); hs_dat.push_back(w_dout); end
      else if (w_dout !== '0) zero_viol++;
      if (frame_done) fd_cyc.push_back(k);
      if (k < 64) busy_log[k] = busy;
      if (k == inj_cyc) begin start = 1'b1; op_sel = inj_op; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_sel = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rd_en, rd_addr, vsync, hsync, busy, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {rd_en, rd_addr, vsync, hsync, busy, frame_done});
    end
    n_tests++;
    if (w_dout !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", w_dout);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({vsync, busy, rd_en, frame_done} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {vsync, busy, rd_en, frame_done});
    end
  endtask

  task automatic test_pass_timing();
    logic [63:0] exp_busy;
    int fd;
    for (int i = 0; i < NPAIR; i++) mem[i] = 48'(i);
    capture(2'b00, 20, -1, 2'b00);
    fd = exp_rd_cyc(NPAIR - 1) + 3;
    n_tests++;
    if (vs_cnt != V || vs_first != 1) begin
      n_fail++; $display("FAIL vsync: got %0d cycles from %0d want %0d from 1", vs_cnt, vs_first, V);
    end
    n_tests++;
    if (rd_cyc.size() != NPAIR) begin
      n_fail++; $display("FAIL rd_count: got %0d want %0d", rd_cyc.size(), NPAIR);
    end
    n_tests++;
    if (hs_cyc.size() != NPAIR) begin
      n_fail++; $display("FAIL hsync_count: got %0d want %0d", hs_cyc.size(), NPAIR);
    end
    for (int i = 0; i < NPAIR && i < rd_cyc.size(); i++) begin
      n_tests++;
      if (rd_cyc[i] != exp_rd_cyc(i) || rd_adr[i] !== 18'(i)) begin
        n_fail++;
        $display("FAIL rd_%0d: got cyc %0d addr %0d want cyc %0d addr %0d", i, rd_cyc[i],
                 rd_adr[i], exp_rd_cyc(i), i);
      end
    end
    for (int i = 0; i < NPAIR && i < hs_cyc.size(); i++) begin
      n_tests++;
      if (hs_cyc[i] != exp_rd_cyc(i) + 2 || hs_dat[i] !== 48'(i)) begin
        n_fail++;
        $display("FAIL hsync_%0d: got cyc %0d data %h want cyc %0d data %h", i, hs_cyc[i],
                 hs_dat[i], exp_rd_cyc(i) + 2, 48'(i));
      end
    end
    n_tests++;
    if (fd_cyc.size() != 1 || fd_cyc[0] != fd) begin
      n_fail++;
      $display("FAIL frame_done: got %0d pulses first %0d want 1 at %0d", fd_cyc.size(),
               (fd_cyc.size() > 0) ? fd_cyc[0] : -1, fd);
    end
    exp_busy = '0;
    for (int k = 1; k <= fd; k++) exp_busy[k] = 1'b1;
    n_tests++;
    if (busy_log !== exp_busy) begin
      n_fail++; $display("FAIL busy: got %h want %h", busy_log, exp_busy);
    end
    n_tests++;
    if (zero_viol != 0 || hold_viol != 0) begin
      n_fail++; $display("FAIL hold: got data %0d addr %0d violations want 0 0", zero_viol, hold_viol);
    end
  endtask

  task automatic test_op_vector(input string name, input logic [1:0] op, input logic [23:0] px0,
                                input logic [23:0] px1, input logic [47:0] want);
    fill_random();
    mem[0] = {px0, px1};
    capture(op, 20, -1, 2'b00);
    n_tests++;
    if (hs_dat.size() < 1 || hs_dat[0] !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, (hs_dat.size() > 0) ? hs_dat[0] : 48'hx, want);
    end
    for (int i = 1; i < NPAIR && i < hs_dat.size(); i++) begin
      n_tests++;
      if (hs_dat[i] !== model_pair(op, mem[i])) begin
        n_fail++;
        $display("FAIL %s_pair%0d: got %h want %h", name, i, hs_dat[i], model_pair(op, mem[i]));
      end
    end
  endtask

  task automatic test_random_frames();
    logic [1:0] op;
    for (int f = 0; f < 6; f++) begin
      fill_random();
      op = 2'($urandom);
      capture(op, 20, -1, 2'b00);
      n_tests++;
      if (hs_dat.size() != NPAIR || fd_cyc.size() != 1) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d pairs %0d done want %0d 1", f, hs_dat.size(),
                 fd_cyc.size(), NPAIR);
      end
      for (int i = 0; i < hs_dat.size() && i < NPAIR; i++) begin
        n_tests++;
        if (hs_dat[i] !== model_pair(op, mem[i])) begin
          n_fail++;
          $display("FAIL rand%0d_op%0d_pair%0d: got %h want %h", f, op, i, hs_dat[i],
                   model_pair(op, mem[i]));
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    fill_random();
    capture(2'b10, 30, 7, 2'b01);
    n_tests++;
    if (fd_cyc.size() != 1 || vs_cnt != V || hs_dat.size() != NPAIR) begin
      n_fail++;
      $display("FAIL restart_ignored: got %0d done %0d vsync %0d pairs want 1 %0d %0d",
               fd_cyc.size(), vs_cnt, hs_dat.size(), V, NPAIR);
    end
    for (int i = 0; i < hs_dat.size() && i < NPAIR; i++) begin
      n_tests++;
      if (hs_dat[i] !== model_pair(2'b10, mem[i])) begin
        n_fail++;
        $display("FAIL restart_op_pair%0d: got %h want %h", i, hs_dat[i], model_pair(2'b10, mem[i]));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int stray;
    fill_random();
    @(negedge clk);
    start = 1'b1; op_sel = 2'b00;
    for (int k = 1; k <= exp_rd_cyc(W / 2); k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++;
    if (rd_en !== 1'b1 || rd_addr !== 18'(W / 2)) begin
      n_fail++; $display("FAIL mid_row1_read: got en %b addr %0d want 1 %0d", rd_en, rd_addr, W / 2);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rd_en, rd_addr, vsync, hsync, busy, frame_done, w_dout} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got en %b addr %0d vs %b hs %b busy %b fd %b data %h want 0",
               rd_en, rd_addr, vsync, hsync, busy, frame_done, w_dout);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (frame_done || vsync || busy || rd_en || hsync) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++; $display("FAIL stay_idle_after_reset: got %0d active cycles want 0", stray);
    end
    capture(2'b11, 20, -1, 2'b00);
    n_tests++;
    if (fd_cyc.size() != 1 || hs_dat.size() != NPAIR || rd_adr.size() != NPAIR) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %0d done %0d pairs %0d reads want 1 %0d %0d",
               fd_cyc.size(), hs_dat.size(), rd_adr.size(), NPAIR, NPAIR);
    end
    for (int i = 0; i < hs_dat.size() && i < NPAIR && i < rd_adr.size(); i++) begin
      n_tests++;
      if (rd_adr[i] !== 18'(i) || hs_dat[i] !== model_pair(2'b11, mem[i])) begin
        n_fail++;
        $display("FAIL post_reset_pair%0d: got addr %0d data %h want %0d %h", i, rd_adr[i],
                 hs_dat[i], i, model_pair(2'b11, mem[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_timing();
    test_op_vector("invert", 2'b01, 24'h0010FF, 24'h123456, {24'hFFEF00, 24'hEDCBA9});
    test_op_vector("bright", 2'b10, 24'hC89B05, 24'h009C10, {24'hFFFF69, 24'h64FF74});
    test_op_vector("thresh", 2'b11, {8'd90, 8'd90, 8'd90}, {8'd90, 8'd90, 8'd89},
                   48'hFFFFFF_000000);
    test_random_frames();
    test_restart_ignored();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
